// File: rtl/bsram_boot_loader.sv
// rtl/bsram_boot_loader.sv - copies a boot image from ROM or a byte stream into BSRAM, then hands the BSRAM to the CPU
module bsram_boot_loader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int LOAD_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              src_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              boot_mode,
  output logic              done,
  output logic [7:0]        checksum
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [2:0] S_START   = 3'd0;
  localparam logic [2:0] S_ROM_RD  = 3'd1;
  localparam logic [2:0] S_ROM_WR  = 3'd2;
  localparam logic [2:0] S_STRM    = 3'd3;
  localparam logic [2:0] S_STRM_WR = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ld_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_din;
  logic [7:0]        r_checksum;

  logic              w_wr_rom;
  logic              w_wr_strm;
  logic              w_wr;
  logic              w_last;
  logic [DATA_W-1:0] w_wr_data;
  logic [7:0]        w_sum;

  assign w_wr_rom  = (r_state == S_ROM_WR);
  assign w_wr_strm = (r_state == S_STRM_WR);
  assign w_wr      = w_wr_rom | w_wr_strm;
  assign w_last    = (r_ld_addr == LAST_ADDR);
  assign w_wr_data = w_wr_rom ? rom_data : r_word;

  // Byte sum of the word being written this cycle, feeds the running checksum
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < BPW; i++) begin
      w_sum = w_sum + w_wr_data[8*i +: 8];
    end
  end

  // Load sequencer: source select, word address, stream byte packing, reload on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_START;
      r_ld_addr <= '0;
      r_cnt     <= '0;
      r_word    <= '0;
    end else begin
      case (r_state)
        S_START: begin
          r_cnt   <= '0;
          r_state <= src_sel ? S_STRM : S_ROM_RD;
        end
        S_ROM_RD: r_state <= S_ROM_WR;
        S_ROM_WR: begin
          if (w_last) begin
            r_state <= S_RUN;
          end else begin
            r_ld_addr <= r_ld_addr + 1'b1;
            r_state   <= S_ROM_RD;
          end
        end
        S_STRM: begin
          if (s_valid) begin
            r_word[{r_cnt, 3'b000} +: 8] <= s_data;
            if (r_cnt == LAST_BYTE) begin
              r_cnt   <= '0;
              r_state <= S_STRM_WR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_STRM_WR: begin
          if (w_last) begin
            r_state <= S_RUN;
          end else begin
            r_ld_addr <= r_ld_addr + 1'b1;
            r_state   <= S_STRM;
          end
        end
        S_RUN: begin
          if (start) begin
            r_ld_addr <= '0;
            r_state   <= S_START;
          end
        end
        default: r_state <= S_START;
      endcase
    end
  end

  // Image checksum and last written word, both captured at the end of each write cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
      r_din      <= '0;
    end else if (w_wr) begin
      r_checksum <= r_checksum + w_sum;
      r_din      <= w_wr_data;
    end else if ((r_state == S_RUN) && start) begin
      r_checksum <= '0;
    end
  end

  // Chip enable follows reset directly so it drops the moment reset asserts
  assign mem_ce    = rst_n;
  assign mem_wre   = w_wr;
  assign mem_addr  = (r_state == S_RUN) ? cpu_addr : r_ld_addr;
  assign mem_din   = w_wr ? w_wr_data : r_din;
  assign rom_addr  = r_ld_addr;
  assign s_ready   = (r_state == S_STRM);
  assign boot_mode = (r_state != S_RUN);
  assign done      = (r_state == S_RUN);
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_bsram_boot_loader.sv
// tb/tb_bsram_boot_loader.sv - directed self-checking bench for bsram_boot_loader
module tb_bsram_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        src_sel;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [10:0] cpu_addr;
  logic        mem_ce;
  logic        mem_wre;
  logic [10:0] mem_addr;
  logic [15:0] mem_din;
  logic        boot_mode;
  logic        done;
  logic [7:0]  checksum;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          done_cyc = 0;
  bit          done_seen = 0;
  int          sr_bad = 0;
  int          wc[$];
  logic [10:0] wa[$];
  logic [15:0] wd[$];

  logic [7:0]  bb[32];
  logic [15:0] exp_w[16];
  logic [7:0]  exp_sum;

  bsram_boot_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_sel   (src_sel),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .cpu_addr  (cpu_addr),
    .mem_ce    (mem_ce),
    .mem_wre   (mem_wre),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .boot_mode (boot_mode),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Write log and cycle counter; cycle 1 is the first cycle after reset release
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      cyc++;
      if (mem_wre) begin
        wc.push_back(cyc);
        wa.push_back(mem_addr);
        wd.push_back(mem_din);
        if (s_ready) sr_bad++;
      end
      if (done && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wc.delete();
    wa.delete();
    wd.delete();
    done_seen = 0;
    sr_bad    = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_wr5(input string tag);
    int k = 0;
    bit hit = 0;
    while (!hit && k < 100) begin
      @(negedge clk); #1;
      hit = mem_wre && (mem_addr == 11'd5);
      k++;
    end
    chk(tag, hit, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit keep);
    int k = 0;
    bit acc = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!acc && k < 100) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      k++;
    end
    chk("send_accept", acc, 1);
    if (!keep) s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Compares the 16 logged writes against exp_w at sequential addresses
  task automatic chk_words(input string tag);
    int bad = 0;
    chk({tag, "_count"}, wa.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i >= wa.size()) bad++;
      else if (wa[i] !== 11'(i) || wd[i] !== exp_w[i]) bad++;
    end
    chk({tag, "_words"}, bad, 0);
  endtask

  task automatic build_stream(input int mul, input int add, input bit spec_head);
    exp_sum = '0;
    for (int i = 0; i < 32; i++) begin
      bb[i] = 8'(i * mul + add);
    end
    if (spec_head) begin
      bb[0] = 8'h34; bb[1] = 8'h12; bb[2] = 8'h78; bb[3] = 8'h56;
    end
    for (int i = 0; i < 16; i++) exp_w[i] = {bb[2*i+1], bb[2*i]};
    for (int i = 0; i < 32; i++) exp_sum = exp_sum + bb[i];
  endtask

  initial begin
    int bad;
    int n0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src_sel  = 1'b0;
    rom_data = 16'h0101;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    cpu_addr = 11'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_wre", mem_wre, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_boot_mode", boot_mode, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_checksum", checksum, 0);

    // ROM load with constant 0x0101: writes in cycles 3,5,..,33, done from 34
    clear_log();
    rst_n = 1'b1;
    wait_done("rom_done");
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h0101;
    chk_words("rom");
    bad = 0;
    for (int i = 0; i < wc.size(); i++) if (wc[i] != 3 + 2 * i) bad++;
    chk("rom_write_cycles", bad, 0);
    chk("rom_done_cycle", done_cyc, 34);
    chk("rom_checksum", checksum, 8'h20);
    chk("rom_din_hold", mem_din, 16'h0101);
    chk("rom_boot_mode", boot_mode, 0);

    // RUN: BSRAM address follows the CPU combinationally
    bad = 0;
    for (int a = 0; a < 2048; a++) begin
      cpu_addr = 11'(a);
      #1;
      if (mem_addr !== 11'(a) || mem_wre !== 1'b0 || mem_ce !== 1'b1) bad++;
    end
    chk("run_sweep", bad, 0);
    chk("run_checksum_hold", checksum, 8'h20);

    // Reload from ROM with new data; start during the load is ignored
    rom_data = 16'h0203;
    clear_log();
    pulse_start();
    chk("reload_done_low", done, 0);
    chk("reload_boot_mode", boot_mode, 1);
    chk("reload_checksum_clr", checksum, 0);
    chk("reload_rom_addr", rom_addr, 0);
    wait_wr5("reload_wr5");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("reload_done");
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h0203;
    chk_words("reload");
    chk("reload_checksum", checksum, 8'h50);

    // Asynchronous reset in the middle of a load
    clear_log();
    pulse_start();
    wait_wr5("abort_wr5");
    rst_n = 1'b0;
    #1;
    n0 = wa.size();
    chk("abort_mem_wre", mem_wre, 0);
    chk("abort_mem_ce", mem_ce, 0);
    chk("abort_done", done, 0);
    chk("abort_boot_mode", boot_mode, 1);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_mem_din", mem_din, 0);
    chk("abort_checksum", checksum, 0);
    src_sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_writes", wa.size(), n0);

    // Stream load with idle gaps after release; src_sel resampled
    build_stream(7, 3, 1'b1);
    clear_log();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) send_byte(bb[i], int'($urandom_range(0, 3)), 1'b0);
    wait_done("strm_done");
    chk_words("strm");
    chk("strm_word0", (wd.size() > 0) ? wd[0] : 16'h0, 16'h1234);
    chk("strm_word1", (wd.size() > 1) ? wd[1] : 16'h0, 16'h5678);
    chk("strm_checksum", checksum, exp_sum);
    chk("strm_done_cycle", done_cyc, (wc.size() > 0) ? wc[wc.size()-1] + 1 : -1);

    // Stream with s_valid held high: no byte lost or duplicated across write cycles
    build_stream(13, 5, 1'b0);
    clear_log();
    pulse_start();
    for (int i = 0; i < 32; i++) send_byte(bb[i], 0, 1'b1);
    s_valid = 1'b0;
    wait_done("bp_done");
    chk_words("bp");
    chk("bp_ready_in_write", sr_bad, 0);
    chk("bp_checksum", checksum, exp_sum);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
